audio_mix_stream: RTL and testbench

AUDIO_MIX_STREAM -- requirements
Module: audio_mix_stream

---
 rtl/audio_mix_pkg.sv | 31 +++
 rtl/audio_sample_fifo.sv | 65 ++++++
 rtl/audio_mix_stream.sv | 175 +++++++++++++++++
 tb/tb_audio_mix_stream.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
// Shared constants and helpers for the audio mixer: default parameters,
// underrun counter width, and a signed saturation function.
// Optional build macro used by the mixer: AUDIO_MIX_CLIP_DETECT_EN.
package audio_mix_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_SAMPLE_W   = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_GAIN_W     = 4;
    localparam int UNDERRUN_W     = 16;

    // Widest value the saturation helper handles; callers sign-extend into it.
    localparam int SAT_MAX_W = 64;
    typedef logic signed [SAT_MAX_W-1:0] wide_t;

    // Clamp a signed value to the range of a w-bit signed number.
    function automatic wide_t sat_signed(input wide_t x, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Purpose: generic synchronous FIFO for mixed samples (power-of-2 depth).
// Latency: push visible in level/head the cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored.
// Ports: clk_i/rst_i (sync active-high), push_i/push_dat_i, pop_i/pop_dat_o
//        (head, combinational), full_o, empty_o, level_o (occupancy).
module audio_sample_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/audio_mix_stream.sv
// Purpose: mixes NUM_CH signed sample streams (per-channel shift gain, mute)
//          into one stream buffered in a FIFO and fed to a codec controller.
// Latency: fire in cycle N -> sample in FIFO (fifo_level up) in cycle N+2;
//          FIFO head appears on mix_down in the same cycle it is written out.
// Backpressure: all channels accepted together (ch_ready = fire) only when
//          every unmuted channel is valid and FIFO space covers in-flight frames.
// Ports: CLOCK_50, reset (sync active-high); ch_data/ch_valid/ch_ready,
//        ch_gain, ch_mute per channel; audio_out_allowed/write_audio_out/
//        mix_down to the codec; fifo_level, underrun_cnt, clip_sticky status.
// Build macro AUDIO_MIX_CLIP_DETECT_EN: saturate the sum and flag clipping;
//        when undefined the sum wraps and clip_sticky is tied low.
module audio_mix_stream
    import audio_mix_pkg::*;
#(
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int SAMPLE_W   = DEF_SAMPLE_W,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int GAIN_W     = DEF_GAIN_W,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]          ch_valid,
    output logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
    input  logic [NUM_CH-1:0]          ch_mute,
    input  logic                       audio_out_allowed,
    output logic                       write_audio_out,
    output logic [SAMPLE_W-1:0]        mix_down,
    output logic [LVL_W-1:0]           fifo_level,
    output logic [UNDERRUN_W-1:0]      underrun_cnt,
    output logic                       clip_sticky
);

    // Sum width leaves headroom so the raw sum of NUM_CH terms never wraps.
    localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH);

    logic                       fifo_full;
    logic                       fifo_empty;
    logic [LVL_W-1:0]           fifo_lvl;
    logic [SAMPLE_W-1:0]        fifo_head;
    logic [SAMPLE_W-1:0]        push_dat;

    logic                       all_rdy;
    logic [LVL_W:0]             occupancy;
    logic                       fire;

    logic                       s1_vld_q;
    logic signed [SAMPLE_W-1:0] term_d [NUM_CH];
    logic signed [SAMPLE_W-1:0] term_q [NUM_CH];
    logic signed [SUM_W-1:0]    sum;

    logic [SAMPLE_W-1:0]        mix_hold_q;
    logic [UNDERRUN_W-1:0]      underrun_q;

    // ---------------------------------------------------------------------
    // Fire decision and stage-1 terms
    // ---------------------------------------------------------------------
    // Muted channels never block a frame; their valid is ignored. The
    // arithmetic shift sign-fills for any shift amount, including >= SAMPLE_W.
    always_comb begin
        all_rdy = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_mute[i] && !ch_valid[i]) begin
                all_rdy = 1'b0;
            end
            if (ch_mute[i]) begin
                term_d[i] = '0;
            end else begin
                term_d[i] = $signed(ch_data[i*SAMPLE_W +: SAMPLE_W]) >>> ch_gain[i*GAIN_W +: GAIN_W];
            end
        end
    end

    // The only in-flight frame is the one held in stage 1; stage 2 is the
    // FIFO write itself, so level plus that frame bounds the occupancy.
    assign occupancy = {1'b0, fifo_lvl} + (LVL_W+1)'(s1_vld_q);
    assign fire      = !reset && all_rdy && !fifo_full
                       && (occupancy < (LVL_W+1)'(FIFO_DEPTH));
    assign ch_ready  = {NUM_CH{fire}};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= fire;
        end
    end

    // Term registers are qualified by s1_vld_q, so they need no reset.
    always_ff @(posedge CLOCK_50) begin
        if (fire) begin
            for (int i = 0; i < NUM_CH; i++) begin
                term_q[i] <= term_d[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: sum and reduce to SAMPLE_W, written straight into the FIFO
    // ---------------------------------------------------------------------
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + SUM_W'(term_q[i]);
        end
    end

`ifdef AUDIO_MIX_CLIP_DETECT_EN
    wide_t sum_wide;
    wide_t sum_sat;
    logic  clip;
    logic  clip_sticky_q;

    assign sum_wide = SAT_MAX_W'(sum);
    assign sum_sat  = sat_signed(sum_wide, SAMPLE_W);
    assign push_dat = sum_sat[SAMPLE_W-1:0];
    assign clip     = s1_vld_q && (sum_sat != sum_wide);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clip_sticky_q <= 1'b0;
        end else if (clip) begin
            clip_sticky_q <= 1'b1;
        end
    end

    assign clip_sticky = clip_sticky_q;
`else
    // Two's-complement wrap: keep the low SAMPLE_W bits of the sum.
    assign push_dat    = sum[SAMPLE_W-1:0];
    assign clip_sticky = 1'b0;
`endif

    audio_sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .push_i     (s1_vld_q),
        .push_dat_i (push_dat),
        .pop_i      (write_audio_out),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_lvl)
    );

    assign fifo_level = fifo_lvl;

    // ---------------------------------------------------------------------
    // Codec side: write strobe, held output sample, underrun counter
    // ---------------------------------------------------------------------
    assign write_audio_out = !reset && audio_out_allowed && !fifo_empty;
    assign mix_down        = write_audio_out ? fifo_head : mix_hold_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mix_hold_q <= '0;
            underrun_q <= '0;
        end else begin
            if (write_audio_out) begin
                mix_hold_q <= fifo_head;
            end
            if (audio_out_allowed && fifo_empty && (underrun_q != {UNDERRUN_W{1'b1}})) begin
                underrun_q <= underrun_q + UNDERRUN_W'(1);
            end
        end
    end

    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_audio_mix_stream.sv
// Directed bench for audio_mix_stream at default parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, well away from the next edge.
module tb_audio_mix_stream;

    localparam int NCH = 4;
    localparam int SW  = 32;
    localparam int GW  = 4;
    localparam int LW  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*SW-1:0] ch_data;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_ready;
    logic [NCH*GW-1:0] ch_gain;
    logic [NCH-1:0]    ch_mute;
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [SW-1:0]     mix_down;
    logic [LW-1:0]     fifo_level;
    logic [15:0]       underrun_cnt;
    logic              clip_sticky;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] exp_clip_mix;
    logic        exp_clip_flag;

    always #5 clk = ~clk;

    audio_mix_stream dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .ch_data           (ch_data),
        .ch_valid          (ch_valid),
        .ch_ready          (ch_ready),
        .ch_gain           (ch_gain),
        .ch_mute           (ch_mute),
        .audio_out_allowed (audio_out_allowed),
        .write_audio_out   (write_audio_out),
        .mix_down          (mix_down),
        .fifo_level        (fifo_level),
        .underrun_cnt      (underrun_cnt),
        .clip_sticky       (clip_sticky)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] d, input logic [3:0] g);
        ch_data[i*SW +: SW] = d;
        ch_gain[i*GW +: GW] = g;
    endtask

    initial begin
`ifdef AUDIO_MIX_CLIP_DETECT_EN
        exp_clip_mix  = 32'h7FFF_FFFF;
        exp_clip_flag = 1'b1;
`else
        exp_clip_mix  = 32'hFFFF_FFFC;
        exp_clip_flag = 1'b0;
`endif
        reset             = 1'b1;
        ch_data           = '0;
        ch_gain           = '0;
        ch_mute           = '0;
        audio_out_allowed = 1'b0;
        for (int i = 0; i < NCH; i++) set_ch(i, 32'd100, 4'd0);
        ch_valid = 4'hF;

        // Reset state, with valid inputs that would otherwise fire
        tick(); tick(); #1;
        chk("rst_ready",    ch_ready, 0);
        chk("rst_level",    fifo_level, 0);
        chk("rst_write",    write_audio_out, 0);
        chk("rst_mix",      mix_down, 0);
        chk("rst_underrun", underrun_cnt, 0);
        chk("rst_clip",     clip_sticky, 0);

        // First fire right after reset; sample in FIFO two cycles later
        reset = 1'b0; #1;
        chk("fire_ready", ch_ready, 4'hF);
        tick(); ch_valid = 4'h0; #1;
        chk("lvl_n1", fifo_level, 0);
        tick(); #1;
        chk("lvl_n2", fifo_level, 1);
        audio_out_allowed = 1'b1; #1;
        chk("w400_write", write_audio_out, 1);
        chk("w400_mix",   mix_down, 400);
        tick(); audio_out_allowed = 1'b0; #1;
        chk("w400_lvl",   fifo_level, 0);
        chk("hold_write", write_audio_out, 0);
        chk("hold_mix",   mix_down, 400);

        // Muted channel with no valid is still drained; gain 1 halves
        ch_mute  = 4'b0100;
        ch_valid = 4'b1011;
        set_ch(0, 32'd1000, 4'd1);
        set_ch(1, 32'd1000, 4'd1);
        set_ch(2, 32'd12345, 4'd1);
        set_ch(3, 32'd1000, 4'd1);
        #1;
        chk("mute_ready", ch_ready, 4'hF);
        tick(); ch_valid = 4'h0; #1;
        chk("mute_noready", ch_ready, 4'h0);
        tick(); #1;
        chk("mute_lvl", fifo_level, 1);
        audio_out_allowed = 1'b1; #1;
        chk("mute_write", write_audio_out, 1);
        chk("mute_mix",   mix_down, 1500);
        tick(); audio_out_allowed = 1'b0; ch_mute = 4'h0; #1;
        chk("mute_lvl0", fifo_level, 0);

        // Underrun: five starved codec slots
        chk("ur_before", underrun_cnt, 0);
        audio_out_allowed = 1'b1;
        repeat (5) begin
            #1;
            chk("ur_write", write_audio_out, 0);
            tick();
        end
        audio_out_allowed = 1'b0; #1;
        chk("ur_count", underrun_cnt, 5);

        // Fill the FIFO: 1+2+3+4 = 10 per frame
        for (int i = 0; i < NCH; i++) set_ch(i, 32'(i + 1), 4'd0);
        ch_valid = 4'hF;
        repeat (12) tick();
        #1;
        chk("full_lvl",   fifo_level, 8);
        chk("full_ready", ch_ready, 4'h0);
        audio_out_allowed = 1'b1; #1;
        chk("full_write", write_audio_out, 1);
        chk("full_mix",   mix_down, 10);
        tick(); audio_out_allowed = 1'b0; #1;
        chk("pop_lvl",    fifo_level, 7);
        chk("pop_ready",  ch_ready, 4'hF);
        tick(); ch_valid = 4'h0; audio_out_allowed = 1'b1; #1;
        chk("pp_write",   write_audio_out, 1);
        tick(); audio_out_allowed = 1'b0; #1;
        chk("pp_lvl",     fifo_level, 7);
        audio_out_allowed = 1'b1;
        repeat (7) begin
            #1;
            chk("drain_write", write_audio_out, 1);
            chk("drain_mix",   mix_down, 10);
            tick();
        end
        audio_out_allowed = 1'b0; #1;
        chk("drain_lvl", fifo_level, 0);
        chk("drain_ur",  underrun_cnt, 5);

        // Negative samples and large shifts: -2 + -1 + 0 + 8 = 5
        set_ch(0, 32'hFFFF_FFF8, 4'd2);
        set_ch(1, 32'hFFFF_FC18, 4'd15);
        set_ch(2, 32'd7, 4'd15);
        set_ch(3, 32'd64, 4'd3);
        ch_valid = 4'hF; #1;
        tick(); ch_valid = 4'h0;
        tick(); audio_out_allowed = 1'b1; #1;
        chk("neg_write", write_audio_out, 1);
        chk("neg_mix",   mix_down, 5);
        tick(); audio_out_allowed = 1'b0; #1;

        // Overflowing sum: saturate or wrap depending on the build
        for (int i = 0; i < NCH; i++) set_ch(i, 32'h7FFF_FFFF, 4'd0);
        ch_valid = 4'hF; #1;
        tick(); ch_valid = 4'h0;
        tick(); #1;
        chk("clip_flag", clip_sticky, exp_clip_flag);
        audio_out_allowed = 1'b1; #1;
        chk("clip_write", write_audio_out, 1);
        chk("clip_mix",   mix_down, exp_clip_mix);
        tick(); audio_out_allowed = 1'b0; #1;

        // Reset with 3 samples buffered and 1 in flight
        for (int i = 0; i < NCH; i++) set_ch(i, 32'd1, 4'd0);
        ch_valid = 4'hF; #1;
        repeat (4) tick();
        #1;
        chk("pre_rst_lvl", fifo_level, 3);
        ch_valid = 4'h0;
        reset = 1'b1;
        audio_out_allowed = 1'b1; #1;
        chk("rst_cyc_write", write_audio_out, 0);
        tick(); #1;
        chk("mid_rst_lvl",   fifo_level, 0);
        chk("mid_rst_write", write_audio_out, 0);
        chk("mid_rst_clip",  clip_sticky, 0);
        chk("mid_rst_ur",    underrun_cnt, 0);
        reset = 1'b0;
        repeat (3) begin
            #1;
            chk("post_rst_write", write_audio_out, 0);
            tick();
            #1;
            chk("post_rst_lvl", fifo_level, 0);
        end
        chk("post_rst_ur", underrun_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
